// File: rtl/cpu_dbg_pkg.sv
// Shared types and defaults for the CPU run/halt/dump debug controller.
package cpu_dbg_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int DUMP_REGS_DEF = 13;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    RD   = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_dump_streamer.sv
// Scans r0..r(DUMP_REGS-1) out of the register file's spare asynchronous read
// port as valid/ready beats, alternating an address-settle cycle and a beat.
module cpu_dump_streamer
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DUMP_REGS = DUMP_REGS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kick_i,
  output logic [ADDR_W-1:0] rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              fin_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_REGS - 1);

  state_t phase;

  // Final beat accepted this cycle; the top moves to DONE on the same edge.
  assign fin_o = (phase == OUT) && dump_ready_i && (dump_idx_o == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase        <= IDLE;
      rf_rd_addr_o <= '0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= '0;
      dump_data_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so dump_idx_o captures the address that
      // was presented during the RD cycle, not the one being written this edge.
      case (phase)
        RD: begin
          dump_data_o  <= rf_rd_data_i;
          dump_idx_o   <= rf_rd_addr_o;
          dump_valid_o <= 1'b1;
          phase        <= OUT;
        end
        OUT: begin
          if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            if (dump_idx_o == LAST_IDX) begin
              phase <= IDLE;
            end else begin
              rf_rd_addr_o <= rf_rd_addr_o + ADDR_W'(1);
              phase        <= RD;
            end
          end
        end
        default: begin
          if (kick_i) begin
            rf_rd_addr_o <= '0;
            phase        <= RD;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/dump sequencer for CPU bring-up: gates the CPU enable for a cycle
// budget, then dumps registers. Define CPU_RUN_CTRL_SINGLE_STEP_EN for halt-to-step.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DUMP_REGS = DUMP_REGS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  cycles_i,
  input  logic              halt_req_i,
  input  logic              step_i,
  output logic              cpu_en_o,
  output logic [ADDR_W-1:0] rf_rd_addr_o,
  input  logic [DATA_W-1:0] rf_rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t           state;
  logic [CNT_W-1:0] budget;
  logic             run_end;
  logic             kick;
  logic             to_step;
  logic             dump_fin;

  // The count is still pre-increment here, so this flags the last enabled cycle.
  assign run_end = (cycle_cnt_o + CNT_W'(1)) == budget;

`ifndef CPU_RUN_CTRL_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step_i;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    kick    = 1'b0;
    to_step = 1'b0;
    case (state)
      IDLE, DONE: kick = start_i && (cycles_i == '0);
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
      RUN: begin
        to_step = halt_req_i;
        kick    = run_end && !halt_req_i;
      end
      STEP: kick = start_i;
`else
      RUN: kick = run_end || halt_req_i;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      budget      <= '0;
      cpu_en_o    <= 1'b0;
      cycle_cnt_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            budget      <= cycles_i;
            cycle_cnt_o <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            if (kick) begin
              state <= RD;
            end else begin
              state    <= RUN;
              cpu_en_o <= 1'b1;
            end
          end
        end
        RUN: begin
          cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
          if (kick) begin
            cpu_en_o <= 1'b0;
            state    <= RD;
          end else if (to_step) begin
            cpu_en_o <= 1'b0;
            state    <= STEP;
          end
        end
`ifdef CPU_RUN_CTRL_SINGLE_STEP_EN
        STEP: begin
          if (cpu_en_o) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
          cpu_en_o <= step_i && !start_i;
          if (kick) state <= RD;
        end
`endif
        // RD covers the whole scan; the streamer sequences its RD/OUT beats.
        RD, OUT: begin
          if (dump_fin) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cpu_dump_streamer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DUMP_REGS(DUMP_REGS)
  ) u_streamer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .kick_i      (kick),
    .rf_rd_addr_o(rf_rd_addr_o),
    .rf_rd_data_i(rf_rd_data_i),
    .dump_valid_o(dump_valid_o),
    .dump_ready_i(dump_ready_i),
    .dump_idx_o  (dump_idx_o),
    .dump_data_o (dump_data_o),
    .fin_o       (dump_fin)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: timeline-based reference model with
// randomized ready/halt/start noise, plus hand-computed pins per scenario.
module tb_cpu_run_ctrl;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int DUMP_REGS = 13;
  localparam int CNT_W     = 16;
  localparam int LIMIT     = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, halt_req, step, dump_ready;
  logic [CNT_W-1:0]  cycles;
  logic              cpu_en, dump_valid, busy, done;
  logic [ADDR_W-1:0] rf_rd_addr, dump_idx;
  logic [DATA_W-1:0] rf_rd_data, dump_data;
  logic [CNT_W-1:0]  cycle_cnt;

  logic [DATA_W-1:0] rf [2**ADDR_W];
  assign rf_rd_data = rf[rf_rd_addr];

  cpu_run_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DUMP_REGS(DUMP_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cycles_i(cycles),
    .halt_req_i(halt_req), .step_i(step), .cpu_en_o(cpu_en),
    .rf_rd_addr_o(rf_rd_addr), .rf_rd_data_i(rf_rd_data),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data),
    .cycle_cnt_o(cycle_cnt), .busy_o(busy), .done_o(done)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model, in timeline terms: k = cycles since the start edge,
  // CPU enabled for cycles 1..n_run, current beat visible from cycle vis_from.
  bit m_started = 1'b0;
  bit m_done    = 1'b0;
  bit cmp_en    = 1'b0;
  int k, n_run, beat, vis_from;
  int en_seen;
  int seen_q[$];

  function automatic bit exp_en();
    return !m_done && (k <= n_run);
  endfunction

  function automatic int exp_cnt();
    if (m_done || (k - 1 >= n_run)) return n_run;
    return k - 1;
  endfunction

  function automatic bit exp_valid();
    return !m_done && (k >= vis_from);
  endfunction

  // Called just after each rising edge, while the inputs of the finished cycle are still driven.
  task automatic model_step();
    if (rst) begin
      m_started = 1'b0;
      m_done    = 1'b0;
      return;
    end
    if (!m_started || m_done) begin
      if (start) begin
        m_started = 1'b1;
        m_done    = 1'b0;
        k         = 1;
        n_run     = int'(cycles);
        beat      = 0;
        vis_from  = n_run + 2;
      end
      return;
    end
    if (k <= n_run && halt_req) begin
      n_run    = k;
      vis_from = k + 2;
    end
    if (k >= vis_from && dump_ready) begin
      if (beat == DUMP_REGS - 1) m_done = 1'b1;
      else begin
        beat++;
        vis_from = k + 2;
      end
    end
    k++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!m_started) begin
        check("idle_cpu_en", cpu_en, 0);
        check("idle_cycle_cnt", cycle_cnt, 0);
        check("idle_valid", dump_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rf_addr", rf_rd_addr, 0);
        check("idle_idx", dump_idx, 0);
        check("idle_data", dump_data, 0);
      end else begin
        check("cpu_en", cpu_en, exp_en());
        check("cycle_cnt", cycle_cnt, exp_cnt());
        check("dump_valid", dump_valid, exp_valid());
        check("busy", busy, !m_done);
        check("done", done, m_done);
        if (exp_valid()) begin
          check("dump_idx", dump_idx, beat);
          check("dump_data", dump_data, rf[beat]);
        end
        if (!m_done && k == vis_from - 1) check("rf_rd_addr", rf_rd_addr, beat);
        en_seen += int'(cpu_en);
        if (dump_valid && dump_ready) seen_q.push_back(int'(dump_idx));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_en"}, cpu_en, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_valid"}, dump_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rf_addr"}, rf_rd_addr, 0);
    check({tag, "_idx"}, dump_idx, 0);
    check({tag, "_data"}, dump_data, 0);
  endtask

  // One start-to-done run. halt_at: enabled-cycle number to halt on (0 = none);
  // stall_beat/rst_beat: beat index to hold off for 5 cycles / reset on (-1 = none);
  // exp_cyc: hand-computed cycle of done after the start edge (-1 = unchecked).
  task automatic run_scenario(input string tag, input int budget, input int halt_at,
                              input int ready_pct, input int stall_beat,
                              input int rst_beat, input int exp_cyc);
    int cyc     = 1;
    int stall_n = 0;
    int exp_n;
    bit did_rst = 1'b0;
    foreach (rf[i]) rf[i] = $urandom;
    seen_q.delete();
    en_seen    = 0;
    start      = 1'b1;
    cycles     = CNT_W'(budget);
    halt_req   = 1'b0;
    dump_ready = 1'b0;
    @(posedge clk); #1; model_step();
    start = 1'b0;
    while (!done && cyc < LIMIT && !did_rst) begin
      bit vis;
      vis      = exp_valid();
      halt_req = (k == halt_at) || (k > n_run && $urandom_range(0, 3) == 0);
      start    = !m_done && ($urandom_range(0, 7) == 0);
      cycles   = CNT_W'($urandom);
      if (rst_beat >= 0 && vis && beat == rst_beat) begin
        rst     = 1'b1;
        start   = 1'b0;
        did_rst = 1'b1;
      end
      if (vis && beat == stall_beat && stall_n < 5) begin
        dump_ready = 1'b0;
        stall_n++;
      end else begin
        dump_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      @(posedge clk); #1; model_step();
      rst = 1'b0;
      cyc++;
    end
    start = 1'b0; halt_req = 1'b0; dump_ready = 1'b0;
    if (did_rst) begin
      check_all_zero({tag, "_after_rst"});
      return;
    end
    exp_n = (halt_at >= 1 && halt_at <= budget) ? halt_at : budget;
    check({tag, "_done_reached"}, done, 1);
    check({tag, "_final_cnt"}, cycle_cnt, exp_n);
    check({tag, "_en_cycles"}, en_seen, exp_n);
    check({tag, "_beats"}, seen_q.size(), DUMP_REGS);
    foreach (seen_q[i]) check({tag, "_beat_order"}, seen_q[i], i);
    if (exp_cyc >= 0) check({tag, "_done_cycle"}, cyc, exp_cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; step = 1'b0;
    dump_ready = 1'b0; cycles = '0;
    foreach (rf[i]) rf[i] = $urandom;
    @(posedge clk); #1; model_step();
    cmp_en = 1'b1;
    @(posedge clk); #1; model_step();
    rst = 1'b0;
    check_all_zero("reset");

    run_scenario("budget25", 25, 0, 100, -1, -1, 52);
    run_scenario("halt7", 100, 7, 100, -1, -1, 34);
    run_scenario("stall3", 10, 0, 100, 3, -1, 42);
    run_scenario("zero", 0, 0, 100, -1, -1, 27);
    run_scenario("rst_mid", 20, 0, 100, -1, 6, -1);
    run_scenario("after_rst", 3, 0, 100, -1, -1, 30);
    for (int r = 0; r < 8; r++) begin
      int b, h;
      b = $urandom_range(0, 40);
      h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (b > 0) ? b : 1) : 0;
      run_scenario("rand", b, h, 60, -1, -1, -1);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt/dump sequencer for Simple_Single_CPU, used for hardware bring-up.
- Gates the CPU clock-enable for a programmed number of cycles, or until an early halt request.
- Then scans the first DUMP_REGS register-file entries out over a valid/ready stream, one entry per transfer.
- Sits beside the CPU: drives its enable and a spare asynchronous register-file read port.

Parameters:
DATA_W, 32, register/dump data width
ADDR_W, 5, register-file address width
DUMP_REGS, 13, number of registers dumped (r0..r(DUMP_REGS-1)), range 1..2^ADDR_W
CNT_W, 16, width of cycle budget and cycle counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle start pulse, honoured in IDLE and DONE only
cycles_i  in  CNT_W  run budget, sampled on an accepted start_i
halt_req_i  in  1  early-stop request, honoured in RUN
step_i  in  1  single-step pulse (used only with the optional feature)
cpu_en_o  out  1  CPU clock-enable, registered
rf_rd_addr_o  out  ADDR_W  register-file read address, registered
rf_rd_data_i  in  DATA_W  asynchronous register-file read data
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump beat accepted
dump_idx_o  out  ADDR_W  register index of the current beat
dump_data_o  out  DATA_W  register value of the current beat, registered
cycle_cnt_o  out  CNT_W  number of enabled cycles in the current run
busy_o  out  1  high in any state except IDLE and DONE
done_o  out  1  high in DONE

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE.
  - All outputs 0: cpu_en_o, rf_rd_addr_o, dump_valid_o, dump_idx_o, dump_data_o, cycle_cnt_o, busy_o, done_o.
  - Reset applies from any state, including mid-RUN and mid-DUMP. Any pending beat is dropped.
- States:
  - IDLE: wait for start.
  - RUN: CPU enabled.
  - RD: register-file address settling.
  - OUT: dump beat presented.
  - DONE: run complete.
- IDLE/DONE + start_i:
  - Latch budget=cycles_i; cycle_cnt_o=0.
  - If cycles_i==0, go to RD with rf_rd_addr_o=0 (no CPU cycles).
  - Otherwise go to RUN with cpu_en_o=1.
  - start_i in any other state is ignored.
- RUN:
  - Each cycle with cpu_en_o=1 increments cycle_cnt_o.
  - cpu_en_o is high for exactly budget consecutive cycles, starting the cycle after the start edge.
  - On the edge where cycle_cnt_o reaches budget, or where halt_req_i=1 is sampled: cpu_en_o=0, rf_rd_addr_o=0, state=RD.
  - halt_req_i and budget expiry on the same edge give a single transition.
  - halt_req_i on the start edge is ignored.
- RD:
  - Exactly 1 cycle.
  - Next edge: dump_data_o=rf_rd_data_i, dump_idx_o=rf_rd_addr_o, dump_valid_o=1, state=OUT.
- OUT:
  - dump_valid_o, dump_idx_o and dump_data_o hold stable until dump_ready_i=1 (AXI-style, no retraction).
  - On handshake: dump_valid_o=0.
    - If dump_idx_o==DUMP_REGS-1, go to DONE.
    - Otherwise rf_rd_addr_o+=1 and go to RD.
  - Throughput: one beat per 2 cycles with ready held high.
- DONE: done_o=1 until the next accepted start_i. cycle_cnt_o holds the final count.
- cycle_cnt_o never exceeds budget ≤ 2^CNT_W-1, so no wrap.

Optional Feature:
CPU_RUN_CTRL_SINGLE_STEP_EN
- Defined:
  - A STEP state is entered from RUN when halt_req_i=1, instead of going to RD.
  - In STEP, step_i=1 gives cpu_en_o=1 for exactly the next cycle and increments cycle_cnt_o.
  - start_i in STEP goes to RD (dump). halt_req_i is ignored in STEP.
- Undefined: step_i is ignored, no STEP state exists, and the flow is as above.

Decomposition:
- Shared package cpu_dbg_pkg contains:
  - the state enum (IDLE, RUN, STEP, RD, OUT, DONE);
  - default DUMP_REGS=13;
  - ADDR_W/DATA_W constants shared with the register file.
- One natural sub-module: cpu_dump_streamer, covering the RD/OUT scan of the register file with the valid/ready hold logic.
- Run/step control stays in the top level.

Test Plan:
- Budget run: start_i with cycles_i=25, ready tied 1.
  - cpu_en_o high for exactly 25 cycles; cycle_cnt_o=25.
  - 13 beats with idx 0..12, data matching the RF model.
  - done_o=1 two cycles after the last beat's RD.
- Early halt: cycles_i=100, halt_req_i pulsed on the 7th enabled cycle → cycle_cnt_o=7, cpu_en_o drops on the next cycle, then the dump proceeds.
- Backpressure: dump_ready_i low for 5 cycles on beat idx 3 → valid/idx/data stable for all 5 cycles, no beat skipped or duplicated.
- Zero budget: cycles_i=0 → cpu_en_o never rises, cycle_cnt_o=0, dump starts immediately.
- Reset mid-DUMP at beat idx 6 → next cycle all outputs 0 and state IDLE. A new start_i with cycles_i=3 runs cleanly.
- With CPU_RUN_CTRL_SINGLE_STEP_EN: halt at cnt=4, three step_i pulses → three single-cycle cpu_en_o pulses, cnt=7; then start_i → dump.
